// File: rtl/cla_pipe_clk.sv
// ---------------------------------------------------------------------------
// cla_pipe_clk -- pipelined carry-lookahead adder/subtractor
//
// A WIDTH-bit add is split into STAGES segments of SEG = WIDTH/STAGES bits.
// Pipeline stage k (1..STAGES) resolves segment k-1 with a SEG-bit
// lookahead adder and registers the partial result, the segment carry-out
// and the still-unresolved (right-shifted) operand bits. Stage STAGES is the
// output register. A single global enable (advance) moves every stage at
// once, so a stall freezes bubbles and data alike.
//
// Parameters:
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  number of pipeline segments (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   a/b/ci/sub carry an operation this cycle
//   in_ready   operation is accepted this cycle if in_valid is high
//   a, b       operands
//   ci         carry-in (add) or borrow-in (subtract)
//   sub        0 = a + b + ci, 1 = a - b - ci
//   out_valid  s/co/ov hold a result
//   out_ready  consumer takes the result this cycle
//   s          sum / difference, truncated to WIDTH bits
//   co         carry-out; in subtract mode 1 means no borrow
//   ov         two's-complement signed overflow
//   z          (only with CLA_PIPE_ZERO_FLAG_EN) 1 when s == 0
//
// Optional feature macro: CLA_PIPE_ZERO_FLAG_EN adds the z output, built up
// as an AND of per-segment zero bits as the operation moves down the pipe.
// ---------------------------------------------------------------------------
module cla_pipe_clk #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
`ifdef CLA_PIPE_ZERO_FLAG_EN
  ,
  output logic             z
`endif
);

  localparam int SEG = WIDTH / STAGES;

  // Flat two-level lookahead: every carry is a direct sum of products of
  // generate/propagate terms and the segment carry-in, so no carry ever
  // ripples through a neighbouring bit's carry.
  function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] g,
                                               input logic [SEG-1:0] p,
                                               input logic           cin);
    logic [SEG:0] c;
    logic         acc;
    logic         term;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      acc = cin;
      for (int k = 0; k <= i; k++) begin
        acc = acc & p[k];
      end
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int m = k + 1; m <= i; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    return c;
  endfunction

  logic             advance;

  // Index 0 is the capture stage; index STAGES is the output register.
  logic             vld_q [0:STAGES];
  logic             cry_q [0:STAGES];
  logic [WIDTH-1:0] a_q   [0:STAGES-1];
  logic [WIDTH-1:0] b_q   [0:STAGES-1];
  logic [WIDTH-1:0] sum_q [1:STAGES];
  logic             ov_q;

  logic [SEG-1:0]   seg_sum  [0:STAGES-1];
  logic             seg_co   [0:STAGES-1];
  logic             seg_cmsb [0:STAGES-1];
  logic [WIDTH-1:0] merged   [0:STAGES-1];

`ifdef CLA_PIPE_ZERO_FLAG_EN
  logic             zf_q      [1:STAGES];
  logic             zf_merged [0:STAGES-1];
`endif

  // The whole pipe moves together unless a result is waiting unaccepted.
  assign advance   = !vld_q[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES];
  assign s         = sum_q[STAGES];
  assign co        = cry_q[STAGES];
  assign ov        = ov_q;
`ifdef CLA_PIPE_ZERO_FLAG_EN
  assign z         = zf_q[STAGES];
`endif

  // Segment j works on the low SEG bits of the operands held in stage j;
  // the operands are shifted right by SEG at every stage, so the next
  // unresolved segment is always at the bottom.
  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    logic [SEG-1:0]   g;
    logic [SEG-1:0]   p;
    logic [SEG:0]     c;
    logic [WIDTH-1:0] ext;

    assign g = a_q[j][SEG-1:0] & b_q[j][SEG-1:0];
    assign p = a_q[j][SEG-1:0] ^ b_q[j][SEG-1:0];
    assign c = cla_carries(g, p, cry_q[j]);

    assign seg_sum[j]  = p ^ c[SEG-1:0];
    assign seg_co[j]   = c[SEG];
    assign seg_cmsb[j] = c[SEG-1];

    // Zero-extend the segment result so it can be placed at its bit offset.
    always_comb begin
      ext          = '0;
      ext[SEG-1:0] = seg_sum[j];
    end

    // Partial results above the resolved segments are always zero, so the
    // new segment can simply be OR-ed in at its offset.
    if (j == 0) begin : g_first
      assign merged[j] = ext;
`ifdef CLA_PIPE_ZERO_FLAG_EN
      assign zf_merged[j] = ~|seg_sum[j];
`endif
    end else begin : g_rest
      assign merged[j] = sum_q[j] | (ext << (j * SEG));
`ifdef CLA_PIPE_ZERO_FLAG_EN
      assign zf_merged[j] = zf_q[j] & ~|seg_sum[j];
`endif
    end
  end

  // Pipeline registers. Subtraction is turned into an add at capture by
  // inverting b and the borrow-in. Internal stages shift bubbles freely;
  // the output register only loads real results so s/co/ov hold their last
  // value while out_valid is low. Signed overflow is the carry into the MSB
  // differing from the carry out of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        sum_q[k] <= '0;
`ifdef CLA_PIPE_ZERO_FLAG_EN
        zf_q[k]  <= 1'b0;
`endif
      end
      ov_q <= 1'b0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= sub ? ~b : b;
      cry_q[0] <= ci ^ sub;

      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        cry_q[k] <= seg_co[k-1];
        a_q[k]   <= a_q[k-1] >> SEG;
        b_q[k]   <= b_q[k-1] >> SEG;
        sum_q[k] <= merged[k-1];
`ifdef CLA_PIPE_ZERO_FLAG_EN
        zf_q[k]  <= zf_merged[k-1];
`endif
      end

      vld_q[STAGES] <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        sum_q[STAGES] <= merged[STAGES-1];
        cry_q[STAGES] <= seg_co[STAGES-1];
        ov_q          <= seg_cmsb[STAGES-1] ^ seg_co[STAGES-1];
`ifdef CLA_PIPE_ZERO_FLAG_EN
        zf_q[STAGES]  <= zf_merged[STAGES-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_clk.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_clk -- directed, self-checking bench for cla_pipe_clk
// (WIDTH=32, STAGES=4). Table vectors carry hand-computed results; the
// streaming and stall sequences use a small arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_cla_pipe_clk;

  localparam int W = 32;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic          ci        = 1'b0;
  logic          sub       = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  s;
  logic          co;
  logic          ov;
`ifdef CLA_PIPE_ZERO_FLAG_EN
  logic          z;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  vec_t        vecs [13];
  res_t        exp_q [$];
  logic [31:0] op_a [8];
  logic [31:0] op_b [8];
  logic        op_ci [8];
  logic        op_sub [8];

  cla_pipe_clk #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
`ifdef CLA_PIPE_ZERO_FLAG_EN
    ,
    .z         (z)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {co,s} = a + b' + ci' with b'/ci' inverted for subtract.
  function automatic res_t model(input logic [31:0] a_i, input logic [31:0] b_i,
                                 input logic ci_i, input logic sub_i);
    logic [31:0] bb;
    logic [32:0] full;
    res_t        r;
    bb   = sub_i ? ~b_i : b_i;
    full = {1'b0, a_i} + {1'b0, bb} + 33'(ci_i ^ sub_i);
    r.s  = full[31:0];
    r.co = full[32];
    r.ov = (a_i[31] == bb[31]) && (r.s[31] != a_i[31]);
    r.z  = (r.s == 32'h0);
    return r;
  endfunction

  // One isolated operation: measure latency and check the result.
  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; ci = v.ci; sub = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("vec%0d latency", idx), 64'(lat), 64'd4);
    checkOutput($sformatf("vec%0d {co,ov,s}", idx), 64'({co, ov, s}),
                64'({v.co, v.ov, v.s}));
`ifdef CLA_PIPE_ZERO_FLAG_EN
    checkOutput($sformatf("vec%0d z", idx), 64'(z), 64'(v.z));
`endif
  endtask

  // Stream nops operations from op_* and optionally hold out_ready low for
  // stall_len cycles starting at the first out_valid.
  task automatic runStream(input int nops, input int stall_len, input string tag);
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    int   first_out = -1;
    int   last_out = -1;
    int   stall_left = 0;
    logic stall_now;
    exp_q.delete();
    while (got < nops && cyc < 80) begin
      @(negedge clk);
      if (out_valid) begin
        if (first_out < 0) begin
          first_out  = cyc;
          stall_left = stall_len;
        end
        checkOutput($sformatf("%s pending", tag), 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          checkOutput($sformatf("%s out%0d {co,ov,s}", tag, got),
                      64'({co, ov, s}),
                      64'({exp_q[0].co, exp_q[0].ov, exp_q[0].s}));
`ifdef CLA_PIPE_ZERO_FLAG_EN
          checkOutput($sformatf("%s out%0d z", tag, got), 64'(z), 64'(exp_q[0].z));
`endif
        end
      end
      stall_now = (stall_left > 0);
      out_ready = !stall_now;
      if (stall_now) stall_left--;
      if (sent < nops) begin
        a = op_a[sent]; b = op_b[sent]; ci = op_ci[sent]; sub = op_sub[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checkOutput($sformatf("%s in_ready c%0d", tag, cyc), 64'(in_ready), 64'(!stall_now));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op_a[sent], op_b[sent], op_ci[sent], op_sub[sent]));
        sent++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput($sformatf("%s result count", tag), 64'(got), 64'(nops));
    checkOutput($sformatf("%s output span", tag), 64'(last_out - first_out + 1),
                64'(nops + stall_len));
  endtask

  initial begin
    int stale;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0001_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    // Reset state, then release mid-cycle.
    #12;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset {co,ov,s}", 64'({co, ov, s}), 64'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("in_ready after reset", 64'(in_ready), 64'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] back-to-back stream");
    for (int i = 0; i < 8; i++) begin
      op_a[i]   = 32'(i);
      op_b[i]   = 32'(i) << 16;
      op_ci[i]  = 1'(i & 1);
      op_sub[i] = 1'b0;
    end
    runStream(8, 0, "stream");

    $display("[TB] backpressure stream");
    for (int i = 0; i < 6; i++) begin
      op_a[i]   = 32'h1000_0000 * 32'(i + 1) + 32'(i);
      op_b[i]   = 32'h0F0F_0F0F ^ 32'(i);
      op_ci[i]  = 1'(i & 1);
      op_sub[i] = 1'((i >> 1) & 1);
    end
    runStream(6, 5, "stall");

    $display("[TB] asynchronous reset with operations in flight");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'hAAAA_0000 + 32'(i); b = 32'h0000_1111; ci = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid-reset {co,ov,s}", 64'({co, ov, s}), 64'd0);
    #10;
    reset_n = 1'b1;
    #1;
    checkOutput("in_ready after mid reset", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("stale results after reset", 64'(stale), 64'd0);
    checkOutput("s after flush", 64'(s), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_clk.md
Name: cla_pipe_clk

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's registered 32-bit CLA.
- Splits a WIDTH-bit add into STAGES segments. Each pipeline stage resolves one segment and forwards its carry in a register.
- Adds a valid/ready handshake with backpressure, an add/subtract mode bit, and a signed-overflow flag.
- Sits between operand-producing datapath blocks and result consumers. Accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments (1..WIDTH); segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/ci/sub are valid this cycle
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  s/co/ov hold a valid result
- out_ready  input  1  consumer accepts the result this cycle
- s  output  WIDTH  sum/difference
- co  output  1  carry-out; in sub mode 1 = no borrow
- ov  output  1  two's-complement signed overflow

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - all stage valid bits clear; out_valid=0;
  - s=0, co=0, ov=0; carry and operand registers 0;
  - in_ready=1 as soon as reset_n=1.
- Reset asserted mid-operation flushes every in-flight operation; nothing is emitted afterwards.
- Arithmetic, sub=0: {co,s} = a + b + ci.
- Arithmetic, sub=1: {co,s} = a + ~b + ~ci, i.e. s = a - b - ci.
  - ~b and the effective carry-in are formed at capture into stage 0.
- ov = (A[W-1] == B'[W-1]) && (s[W-1] != A[W-1]), where B' is the effective (possibly inverted) B.
- Pipeline structure:
  - Stage 0 register holds operand A, effective B and the effective carry-in.
  - Stage k (1..STAGES) register holds:
    - result bits [k*SEG-1:0] as resolved;
    - the carry out of segment k-1;
    - the remaining unresolved operand bits (skewed);
    - a valid bit.
  - Each segment is a SEG-bit CLA: generate/propagate with a lookahead carry tree; no ripple across bit positions within a segment.
  - Stage STAGES is the output register: s, co, ov, out_valid.
- Latency:
  - An operation accepted at rising edge k appears with out_valid=1 after edge k+STAGES, when there is no stall.
  - Throughput is 1 operation/cycle.
- Handshake:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Transfer out occurs when out_valid && out_ready.
  - Global enable: advance = !out_valid || out_ready. in_ready = advance (combinational from out_valid/out_ready only, never from in_valid).
  - When advance=0, all stage registers hold, including bubbles, and s/co/ov stay stable while out_valid=1.
  - When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Simultaneous events: out_ready=1 and in_valid=1 in the same cycle produce an output pop and an input accept on the same edge, with no lost cycle.
- Output hold: s/co/ov keep their last value when out_valid=0; they are not forced to 0.
- Wrap-around: the sum is truncated to WIDTH bits; the carry is reported only on co.
- STAGES=1 degenerates to input register + full-width CLA + output register (latency 1).

Optional Feature:
- Macro: CLA_PIPE_ZERO_FLAG_EN.
- Defined:
  - adds output port z (1 bit): z=1 iff s==0 for the presented result;
  - z is accumulated per segment through the pipeline (AND of segment-zero bits), not by a full-width compare at the output;
  - z resets to 0 and obeys the same hold/stall rules as s.
- Undefined: port z and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=32, STAGES=4):
- Reset release then single add a=0xFFFF_FFFF, b=0x0000_0001, ci=0, sub=0 accepted at edge k -> out_valid=1 after edge k+4, s=0x0000_0000, co=1, ov=0 (z=1 when enabled).
- Subtract a=0x8000_0000, b=0x0000_0001, ci=0, sub=1 -> s=0x7FFF_FFFF, co=1, ov=1.
- Back-to-back stream of 8 adds (a=i, b=i<<16, ci=i[0]) with out_ready=1 -> 8 consecutive out_valid cycles in order, each s=i+(i<<16)+i[0], no gaps.
- Backpressure: stream 6 ops, out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, s stable, no op lost or duplicated, order preserved after release.
- Carry across every segment boundary: a=0x00FF_FFFF, b=0x0000_0001, ci=0 -> s=0x0100_0000; a=0x7FFF_FFFF, b=0, ci=1 -> s=0x8000_0000, ov=1.
- reset_n pulsed low asynchronously (mid-cycle) with 3 ops in flight -> out_valid=0, s=0, co=0, ov=0 immediately; after release no stale result ever appears.
